// File: rtl/result_readout.sv
// ---------------------------------------------------------------------------
// result_readout
//   Reads NUM_WORDS 32-bit result words from SRAM (addresses 0..NUM_WORDS-1)
//   and streams each word out as four bytes, most significant byte first,
//   over a valid/ready byte interface. The block only owns the SRAM port
//   while rd_busy_o is high; the surrounding top uses rd_busy_o as the SRAM
//   mux select.
//
// Ports
//   clk_i          clock, all state on the rising edge
//   rst_ni         asynchronous active-low reset
//   start_i        run request, level-sampled in IDLE only
//   sram_cs_n_o    SRAM chip select (active low), asserted in READ only
//   sram_we_n_o    SRAM write enable, permanently high
//   sram_addr_o    SRAM read address (holds its value outside READ)
//   sram_rdata_i   SRAM read data, valid RD_LAT cycles after the READ cycle
//   out_data_o     result byte
//   out_valid_o    out_data_o valid
//   out_ready_i    consumer accepts a byte when valid && ready
//   rd_busy_o      high in every state except IDLE
//   rd_done_o      single-cycle pulse after the last byte is accepted
//
// States
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start_i; SRAM port released
//   ST_READ  | one cycle, chip select low, address = word counter
//   ST_WAIT  | RD_LAT cycles; read data captured on the last one
//   ST_SHIFT | presenting shreg[31:24]; shifts left by 8 per accepted byte
//   ST_DONE  | one-cycle rd_done_o pulse, then back to IDLE
// ---------------------------------------------------------------------------
module result_readout #(
    parameter int ADDR_W    = 8,
    parameter int NUM_WORDS = 16,
    parameter int RD_LAT    = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    output logic              sram_cs_n_o,
    output logic              sram_we_n_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    input  logic [31:0]       sram_rdata_i,
    output logic [7:0]        out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              rd_busy_o,
    output logic              rd_done_o
);

    localparam int                LAT_W     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS - 1);
    localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(RD_LAT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic [31:0]       shreg_q, shreg_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            lat_cnt_q  <= '0;
            shreg_q    <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            shreg_q    <= shreg_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        shreg_d    = shreg_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    word_cnt_d = '0;
                    state_d    = ST_READ;
                end
            end
            ST_READ: begin
                // Wait timer is a down-counter; terminal count 0 marks the
                // cycle in which the SRAM data is valid.
                lat_cnt_d = LAT_LOAD;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_cnt_q == '0) begin
                    shreg_d    = sram_rdata_i;
                    byte_cnt_d = '0;
                    state_d    = ST_SHIFT;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            ST_SHIFT: begin
                if (out_ready_i) begin
                    shreg_d    = {shreg_q[23:0], 8'h00};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (word_cnt_q == LAST_WORD) begin
                            state_d = ST_DONE;
                        end else begin
                            word_cnt_d = word_cnt_q + ADDR_W'(1);
                            state_d    = ST_READ;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode directly from the state register so an asynchronous
    // reset takes them to their idle values in the same cycle.
    assign sram_cs_n_o = (state_q != ST_READ);
    assign sram_we_n_o = 1'b1;
    // The word counter doubles as the address register: it only changes on
    // entry to READ, so the address holds its last value elsewhere.
    assign sram_addr_o = word_cnt_q;
    assign out_valid_o = (state_q == ST_SHIFT);
    assign out_data_o  = (state_q == ST_SHIFT) ? shreg_q[31:24] : 8'h00;
    assign rd_busy_o   = (state_q != ST_IDLE);
    assign rd_done_o   = (state_q == ST_DONE);

endmodule
